// File: rtl/dg0045_pkg.sv
// Shared constants for the DG0045 display path: segment table, width helper and
// default geometry for the scan block.
package dg0045_pkg;

  localparam int DIGITS_DEF        = 4;
  localparam int SCAN_DIV_DEF      = 256;
  localparam int FRAME_TIMEOUT_DEF = 64;

  // Segment patterns {g,f,e,d,c,b,a}; element 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dg0045_hex7seg.sv
// Combinational nibble to 7-segment decode for a common-cathode display.
module dg0045_hex7seg
  import dg0045_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/dg0045_display_scan.sv
// Captures strobed nibbles from the DG0045 core into a digit buffer and
// multiplexes the buffer onto a common-cathode 7-segment display.
module dg0045_display_scan
  import dg0045_pkg::*;
#(
  parameter  int DIGITS        = DIGITS_DEF,
  parameter  int SCAN_DIV      = SCAN_DIV_DEF,
  parameter  int FRAME_TIMEOUT = FRAME_TIMEOUT_DEF,
  localparam int PTR_W         = clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              nd,
  input  logic [3:0]        nl,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel,
  output logic [PTR_W-1:0]  wr_ptr_o
);

  localparam int TO_W  = clog2(FRAME_TIMEOUT + 1);
  localparam int PRE_W = clog2(SCAN_DIV);

  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(FRAME_TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic                   s1_q, s2_q, s3_q;
  logic [3:0]             nl1_q, nl2_q;
  logic [DIGITS-1:0][3:0] dbuf_q, dbuf_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [PRE_W-1:0]       presc_q, presc_d;
  logic [PTR_W-1:0]       idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      dig_sel_q, dig_sel_d;
  logic                   wr_stb;
  logic                   to_hit;

  // The end of the low pulse marks a write; nl rides the same two flops so the
  // nibble seen at the edge is the one the core presented with the strobe.
  assign wr_stb = s2_q & ~s3_q;
  // A strobe landing on the edge where the counter saturates is treated as a
  // new frame, so the frame decision looks one count ahead.
  assign to_hit = (to_q >= (TO_MAX - TO_W'(1)));

  always_comb begin
    dbuf_d   = dbuf_q;
    wr_ptr_d = wr_ptr_q;
    to_d     = to_q;
    if (wr_stb) begin
      to_d = '0;
      if (to_hit) begin
        dbuf_d[0] = ~nl2_q;
        wr_ptr_d  = PTR_W'(1);
      end else begin
        dbuf_d[wr_ptr_q] = ~nl2_q;
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
    end else begin
      if (to_q != TO_MAX) to_d = to_q + TO_W'(1);
      if (to_hit) wr_ptr_d = '0;
    end
  end

  dg0045_hex7seg u_hex7seg (
    .nib_i (dbuf_q[idx_q]),
    .seg_o (seg_d)
  );

  always_comb begin
    presc_d   = presc_q + PRE_W'(1);
    idx_d     = idx_q;
    dig_sel_d = DIGITS'(1) << idx_q;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == LAST_PTR) ? '0 : idx_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      nl1_q     <= 4'hF;
      nl2_q     <= 4'hF;
      dbuf_q    <= '0;
      wr_ptr_q  <= '0;
      to_q      <= TO_MAX;
      presc_q   <= '0;
      idx_q     <= '0;
      seg_q     <= '0;
      dig_sel_q <= '0;
    end else if (ena) begin
      s1_q      <= nd;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      nl1_q     <= nl;
      nl2_q     <= nl1_q;
      dbuf_q    <= dbuf_d;
      wr_ptr_q  <= wr_ptr_d;
      to_q      <= to_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign seg      = seg_q;
  assign dig_sel  = dig_sel_q;
  assign wr_ptr_o = wr_ptr_q;

endmodule

// File: tb/tb_dg0045_display_scan.sv
// Bench for dg0045_display_scan: directed scenarios plus random strobe traffic,
// checked every clock against an event-level model of capture, framing and scan.
module tb_dg0045_display_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FT       = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              nd = 1'b1;
  logic [3:0]        nl = 4'hF;
  logic [6:0]        seg;
  logic [DIGITS-1:0] dig_sel;
  logic [1:0]        wr_ptr_o;

  dg0045_display_scan #(
    .DIGITS        (DIGITS),
    .SCAN_DIV      (SCAN_DIV),
    .FRAME_TIMEOUT (FT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .nd       (nd),
    .nl       (nl),
    .seg      (seg),
    .dig_sel  (dig_sel),
    .wr_ptr_o (wr_ptr_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: k counts enabled edges since reset, last_w is the edge of
  // the last buffer write, exp_e/exp_q hold pending writes (edge, nibble).
  int                k;
  int                last_w;
  int                mptr;
  logic [3:0]        mbuf [DIGITS];
  logic              prev_nd;
  int                exp_e [$];
  logic [3:0]        exp_q [$];
  logic [6:0]        exp_seg;
  logic [DIGITS-1:0] exp_dig;

  function automatic logic [6:0] hex_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    last_w  = -100000;
    mptr    = 0;
    prev_nd = 1'b1;
    for (int i = 0; i < DIGITS; i++) mbuf[i] = 4'h0;
    exp_e.delete();
    exp_q.delete();
    exp_seg = '0;
    exp_dig = '0;
  endtask

  task automatic tick();
    int         idx;
    int         slot;
    logic [3:0] d;
    @(posedge clk);
    if (rst_n && ena) begin
      k++;
      idx     = ((k - 1) / SCAN_DIV) % DIGITS;
      exp_seg = hex_ref(mbuf[idx]);
      exp_dig = DIGITS'(1) << idx;
      if (exp_e.size() > 0 && exp_e[0] == k) begin
        void'(exp_e.pop_front());
        d = exp_q.pop_front();
        if (k - last_w >= FT) begin
          slot = 0;
          mptr = 1;
        end else begin
          slot = mptr;
          mptr = (mptr + 1) % DIGITS;
        end
        mbuf[slot] = d;
        last_w     = k;
      end else if (k - last_w >= FT) begin
        mptr = 0;
      end
      if (!prev_nd && nd) begin
        exp_e.push_back(k + 2);
        exp_q.push_back(~nl);
      end
      prev_nd = nd;
    end
    #1;
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("dig_sel", 32'(dig_sel), 32'(exp_dig));
    chk("wr_ptr", 32'(wr_ptr_o), 32'(mptr));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [3:0] v);
    nl = ~v;
    nd = 1'b0;
    tick();
    tick();
    nd = 1'b1;
    repeat (6) tick();
  endtask

  // Wait (bounded) until digit d is selected, then check its segments.
  task automatic show(input int d, input logic [6:0] want, input string tag);
    int n;
    n = 0;
    while (dig_sel !== (DIGITS'(1) << d) && n < 4 * SCAN_DIV + 4) begin
      tick();
      n++;
    end
    chk({tag, "_sel"}, 32'(dig_sel), 32'(DIGITS'(1) << d));
    chk(tag, 32'(seg), 32'(want));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int te;
    int n;
    int r;

    model_reset();
    rst_n = 1'b0;
    ena   = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Idle after reset: digit 0 shows blank-value zero
    repeat (4) tick();
    chk("idle_seg", 32'(seg), 32'h3F);
    chk("idle_dig", 32'(dig_sel), 32'h1);
    chk("idle_ptr", 32'(wr_ptr_o), 32'h0);
    tick();

    // Fill a full frame
    pulse(4'h1);
    pulse(4'h2);
    pulse(4'h3);
    pulse(4'h4);
    chk("frame_ptr", 32'(wr_ptr_o), 32'h0);
    show(0, 7'h06, "frame_d0");
    show(1, 7'h5B, "frame_d1");
    show(2, 7'h4F, "frame_d2");
    show(3, 7'h66, "frame_d3");

    // Gap longer than the timeout restarts the frame at digit 0
    pulse(4'h7);
    pulse(4'h8);
    idle(64);
    chk("to_ptr0", 32'(wr_ptr_o), 32'h0);
    pulse(4'h9);
    chk("to_ptr", 32'(wr_ptr_o), 32'h1);
    show(0, 7'h6F, "to_d0");
    show(1, 7'h7F, "to_d1");

    // Clock enable low: strobes ignored, timeout frozen
    pulse(4'h5);
    ena = 1'b0;
    for (int i = 0; i < 100; i++) begin
      nd = ((i % 10) < 3) ? 1'b0 : 1'b1;
      nl = 4'($urandom);
      tick();
    end
    nd  = 1'b1;
    ena = 1'b1;
    pulse(4'h6);
    chk("ena_ptr", 32'(wr_ptr_o), 32'h3);
    show(1, 7'h6D, "ena_d1");
    show(2, 7'h7D, "ena_d2");

    // Write lands on the exact edge the timeout saturates
    te = last_w + FT - 2;
    n  = 0;
    while (k < te - 3 && n < 200) begin
      tick();
      n++;
    end
    chk("coin_align", 32'(k), 32'(te - 3));
    nl = ~4'hE;
    nd = 1'b0;
    tick();
    tick();
    nd = 1'b1;
    tick();
    tick();
    tick();
    chk("coin_ptr", 32'(wr_ptr_o), 32'h1);
    idle(2);
    show(0, 7'h79, "coin_d0");
    show(3, 7'h66, "coin_d3");

    // Asynchronous reset in the middle of a scan
    idle(70);
    pulse(4'hA);
    pulse(4'hB);
    pulse(4'hC);
    pulse(4'hD);
    show(0, 7'h77, "pre_rst_d0");
    show(3, 7'h5E, "pre_rst_d3");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(seg), 32'h0);
    chk("arst_dig", 32'(dig_sel), 32'h0);
    chk("arst_ptr", 32'(wr_ptr_o), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_seg", 32'(seg), 32'h3F);
    chk("post_rst_dig", 32'(dig_sel), 32'h1);
    show(2, 7'h3F, "post_rst_d2");

    // Random traffic
    repeat (150) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        pulse(4'($urandom_range(0, 15)));
        idle($urandom_range(0, 6));
      end else if (r == 6) begin
        idle($urandom_range(40, 80));
      end else if (r == 7) begin
        ena = 1'b0;
        n   = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) begin
          nd = 1'($urandom_range(0, 1));
          nl = 4'($urandom);
          tick();
        end
        nd  = 1'b1;
        ena = 1'b1;
        tick();
      end else begin
        nl = 4'($urandom);
        nd = 1'b0;
        tick();
        nd = 1'b1;
        idle($urandom_range(3, 8));
      end
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dg0045_display_scan.md
Name: dg0045_display_scan

Overview:
- Downstream output stage of the DG0045 4-bit CPU core.
- Consumes the core's ND strobe and nL[3:0] nibble outputs, captures each strobed nibble into a digit buffer, and time-multiplexes that buffer onto a common-cathode 7-segment display.
- Runs on the same clock as the core and recovers frame alignment from gaps in strobe activity.

Parameters:
- DIGITS, 4: number of display digits / buffer entries; must be 2..8.
- SCAN_DIV, 256: enabled clocks each digit stays selected; must be >= 2.
- FRAME_TIMEOUT, 64: enabled clocks with no strobe before the write pointer returns to 0 (64 = 8 CPU machine cycles).

Ports:
- clk  input  1  system clock, rising-edge; the same clock that feeds the CPU core.
- rst_n  input  1  asynchronous reset, active low.
- ena  input  1  clock enable; when 0, all state holds.
- nd  input  1  strobe from the core, active low; the low pulse lasts ~2 clocks.
- nl  input  4  nibble from the core, active low (nl = ~Lreg).
- seg  output  7  segments {g,f,e,d,c,b,a}, active high, registered.
- dig_sel  output  DIGITS  one-hot digit enable, active high, registered.
- wr_ptr_o  output  clog2(DIGITS)  current write pointer, for debug and verification.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is asynchronous assert, active low, and is released synchronously by the integrating design.
  - All flops are reset, including every buffer entry.
- Reset values:
  - seg = 0, dig_sel = 0, wr_ptr = 0, buf[*] = 0.
  - Timeout counter = FRAME_TIMEOUT, i.e. expired.
  - Scan prescaler = 0, scan digit index = 0.
  - Strobe synchroniser flops = 1 (idle).
- ena = 0:
  - No register changes and no strobe is detected.
  - Strobe edges that occur while ena = 0 are lost; this is accepted behaviour.
- Strobe capture:
  - nd passes through 2 flops (s1, s2), then a third flop s3 for edge detection.
  - wr_stb = s2 & ~s3 (rising edge of nd, i.e. the end of the pulse).
  - nl is sampled with the same 2-flop delay so data stays aligned with the edge; the captured value is data = ~nl_s2.
  - Latency: nd rising at edge N → buffer written at edge N+3.
- Write pointer:
  - On wr_stb, if the timeout has expired: write buf[0], then wr_ptr = 1.
  - On wr_stb otherwise: write buf[wr_ptr], then wr_ptr = wr_ptr+1, wrapping DIGITS-1 → 0.
  - Every wr_stb reloads the timeout counter to 0.
  - With no wr_stb, the timeout counter increments and saturates at FRAME_TIMEOUT.
  - When the counter reaches FRAME_TIMEOUT, wr_ptr is forced to 0 on that same edge.
  - When timeout and wr_stb coincide, the timeout case applies: write to digit 0.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the scan index advances, wrapping DIGITS-1 → 0.
  - Registered outputs on every enabled edge:
    - dig_sel = 1 << scan_idx.
    - seg = hex7(buf[scan_idx]), using the buffer value after any write on the previous edge.
  - dig_sel is 0 only during reset; it becomes one-hot on the first enabled edge after reset.
- Simultaneous events:
  - A write to the currently displayed digit appears on seg one clock later.
  - A write and a scan advance on the same edge are independent.
- Reset mid-operation: every output goes to its reset value immediately (asynchronous); the buffer is cleared.
- Hex decode (segment encodings):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07.
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71.
  - No blanking code.

Decomposition:
- Shared package dg0045_pkg holds:
  - The 16-entry 7-segment constant table.
  - A clog2 helper function.
  - Default values for DIGITS, SCAN_DIV and FRAME_TIMEOUT.
- One sub-module, dg0045_hex7seg: purely combinational 4→7 decode, instantiated once on the scan read path.

Test Plan:
- Reset, then 5 enabled clocks with nd = 1 → seg = 3F, dig_sel = 0001, wr_ptr_o = 0.
- Four nd low pulses (2 clocks each, 8 clocks apart) with nl = ~1, ~2, ~3, ~4, SCAN_DIV = 4 → digits 0..3 display 06, 5B, 4F, 66 in rotation; wr_ptr_o = 0 after wrap.
- Two strobes writing 7 and 8, then 64 idle clocks, then strobe with nl = ~9 → buf[0] = 9 (seg 6F on digit 0), buf[1] = 8 remains, wr_ptr_o = 1.
- Hold ena = 0 for 100 clocks while pulsing nd → no buffer change; seg and dig_sel frozen; timeout counter not advanced.
- Strobe completes on the same edge the timeout saturates → write lands in buf[0], wr_ptr_o = 1.
- Assert rst_n low mid-scan with buf = {A,b,C,d} → seg = 0 and dig_sel = 0 asynchronously; after release digit 0 shows 3F.
